// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM states and write-port address match for the multi-port register file
package regfile_pkg;
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;
    typedef enum logic {IDLE = ST_IDLE, CLEAR = ST_CLEAR} state_t;
    function automatic logic [1:0] wr_hit(input logic [1:0] we, input logic [31:0] wa_a,
                                          input logic [31:0] wa_b, input logic [31:0] addr);
        return {we[1] && wa_b == addr, we[0] && wa_a == addr};
    endfunction
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: sweeps every entry to zero after reset or a soft-clear request
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_idx
);
    state_t state, nxt;
    logic [ADDR_W-1:0] idx;
    always_comb begin
        nxt = state;
        nxt = (state == CLEAR) ? ((idx == '1) ? IDLE : CLEAR) : (clr_req ? CLEAR : IDLE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= nxt;
            idx   <= (state == CLEAR) ? idx + 1'b1 : '0;
        end
    end
    assign busy    = (state == CLEAR);
    assign clr_en  = busy & ~reset;
    assign clr_idx = idx;
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: two-write, N-read register file with bypass, zero entry and clear engine
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_req,
    output logic                     busy,
    input  logic [1:0]               we,
    input  logic [2*ADDR_W-1:0]      wa,
    input  logic [2*DATA_W-1:0]      wd,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd
);
    localparam int DEPTH = 1 << ADDR_W;
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [ADDR_W-1:0] wa_a, wa_b, clr_idx;
    logic [DATA_W-1:0] wd_a, wd_b;
    logic [1:0] hb;
    logic clr_en, wen_a, wen_b;
    assign wa_a = wa[ADDR_W-1:0];
    assign wa_b = wa[2*ADDR_W-1:ADDR_W];
    assign wd_a = wd[DATA_W-1:0];
    assign wd_b = wd[2*DATA_W-1:DATA_W];
    regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
        .clk(clk), .reset(reset), .clr_req(clr_req),
        .busy(busy), .clr_en(clr_en), .clr_idx(clr_idx)
    );
    // hb[0] set means port A targets port B's address, so B yields
    assign hb    = wr_hit(we, 32'(wa_a), 32'(wa_b), 32'(wa_b));
    assign wen_a = we[0] & ~busy & ~(ZERO_REG != 0 && wa_a == '0);
    assign wen_b = hb[1] & ~hb[0] & ~busy & ~(ZERO_REG != 0 && wa_b == '0);
    always_ff @(posedge clk) begin
        if (clr_en) mem[clr_idx] <= '0;
        else if (!reset) begin
            if (wen_a) mem[wa_a] <= wd_a;
            if (wen_b) mem[wa_b] <= wd_b;
        end
    end
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [1:0] h;
        assign a = ra[i*ADDR_W +: ADDR_W];
        assign h = (BYPASS != 0) ? wr_hit(we, 32'(wa_a), 32'(wa_b), 32'(a)) : 2'b00;
        assign rd[i*DATA_W +: DATA_W] = (busy || (ZERO_REG != 0 && a == '0)) ? '0 :
                                        h[0] ? wd_a : h[1] ? wd_b : mem[a];
    end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed checks of sweep, writes, collision, zero entry, bypass and clear
module tb_register_file_mp;
    logic clk = 0, reset = 0, clr_req = 0, busy, busy_nb;
    logic [1:0] we = 0;
    logic [9:0] wa = 0, ra = 0;
    logic [63:0] wd = 0, rd, rd_nb;
    int cmp = 0, bad = 0;

    register_file_mp dut (.clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy),
                          .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd));
    register_file_mp #(.BYPASS(0)) u_nb (.clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_nb),
                          .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_nb));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        int zbad = 0;
        while (busy && n < 100) begin
            if (rd !== 64'd0) zbad++;
            n++;
            tick();
        end
        cmp++;
        if (n != 32) begin bad++; $display("FAIL %s busy cycles: got %0d want 32", name, n); end
        cmp++;
        if (zbad != 0) begin bad++; $display("FAIL %s rd nonzero while busy: got %0d cycles want 0", name, zbad); end
    endtask

    task automatic test_reset;
        reset = 1;
        we = 2'b11; wa = {5'd4, 5'd3}; wd = {32'hAAAA_0004, 32'hAAAA_0003}; ra = {5'd4, 5'd3};
        tick();
        reset = 0;
        cmp++;
        if (busy !== 1'b1) begin bad++; $display("FAIL reset busy: got %b want 1", busy); end
        count_busy("reset");
        we = 0;
        #1;
        cmp++;
        if (rd !== 64'd0) begin bad++; $display("FAIL reset writes ignored: got %h want 0", rd); end
        cmp++;
        if (busy_nb !== 1'b0) begin bad++; $display("FAIL reset nb idle: got %b want 0", busy_nb); end
    endtask

    task automatic test_basic;
        we = 2'b11; wa = {5'd9, 5'd5}; wd = {32'h1234_5678, 32'hDEAD_BEEF};
        tick();
        we = 0; ra = {5'd9, 5'd5};
        #1;
        cmp++;
        if (rd !== {32'h1234_5678, 32'hDEAD_BEEF}) begin bad++; $display("FAIL basic rd: got %h want 12345678deadbeef", rd); end
        cmp++;
        if (rd_nb !== {32'h1234_5678, 32'hDEAD_BEEF}) begin bad++; $display("FAIL basic rd_nb: got %h want 12345678deadbeef", rd_nb); end
    endtask

    task automatic test_collision;
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h2222, 32'h1111}; ra = {5'd9, 5'd7};
        #1;
        cmp++;
        if (rd[31:0] !== 32'h1111) begin bad++; $display("FAIL collision bypass: got %h want 1111", rd[31:0]); end
        tick();
        we = 0;
        #1;
        cmp++;
        if (rd[31:0] !== 32'h1111) begin bad++; $display("FAIL collision stored: got %h want 1111", rd[31:0]); end
        cmp++;
        if (rd_nb[31:0] !== 32'h1111) begin bad++; $display("FAIL collision stored nb: got %h want 1111", rd_nb[31:0]); end
    endtask

    task automatic test_zero;
        we = 2'b11; wa = {5'd0, 5'd0}; wd = {32'hFFFF_FFFF, 32'hFFFF_FFFF}; ra = {5'd0, 5'd0};
        #1;
        cmp++;
        if (rd !== 64'd0) begin bad++; $display("FAIL zero same cycle: got %h want 0", rd); end
        tick();
        we = 0;
        #1;
        cmp++;
        if (rd !== 64'd0 || rd_nb !== 64'd0) begin bad++; $display("FAIL zero after: got %h/%h want 0", rd, rd_nb); end
    endtask

    task automatic test_bypass;
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h5555};
        tick();
        we = 2'b10; wa = {5'd3, 5'd0}; wd = {32'hABCD, 32'h0}; ra = {5'd5, 5'd3};
        #1;
        cmp++;
        if (rd[31:0] !== 32'hABCD) begin bad++; $display("FAIL bypass on: got %h want abcd", rd[31:0]); end
        cmp++;
        if (rd_nb[31:0] !== 32'h5555) begin bad++; $display("FAIL bypass off: got %h want 5555", rd_nb[31:0]); end
        cmp++;
        if (rd[63:32] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass other port: got %h want deadbeef", rd[63:32]); end
        tick();
        we = 0;
        #1;
        cmp++;
        if (rd[31:0] !== 32'hABCD || rd_nb[31:0] !== 32'hABCD) begin bad++; $display("FAIL bypass after edge: got %h/%h want abcd", rd[31:0], rd_nb[31:0]); end
    endtask

    task automatic fill;
        for (int i = 1; i < 32; i++) begin
            we = 2'b01; wa = {5'd0, 5'(i)}; wd = {32'h0, 32'h100 + 32'(i)};
            tick();
        end
        we = 0;
    endtask

    task automatic test_clear;
        int nz = 0;
        fill();
        ra = {5'd31, 5'd1};
        #1;
        cmp++;
        if (rd !== {32'h11F, 32'h101}) begin bad++; $display("FAIL fill: got %h want 0000011f00000101", rd); end
        clr_req = 1;
        tick();
        clr_req = 0;
        count_busy("soft clear");
        for (int i = 1; i < 32; i++) begin
            ra = {5'd0, 5'(i)};
            #1;
            if (rd[31:0] !== 32'd0) nz++;
        end
        cmp++;
        if (nz != 0) begin bad++; $display("FAIL soft clear contents: got %0d nonzero want 0", nz); end
        fill();
        clr_req = 1;
        tick();
        clr_req = 0;
        repeat (10) tick();
        reset = 1;
        tick();
        reset = 0;
        count_busy("reset mid-sweep");
        nz = 0;
        for (int i = 1; i < 32; i++) begin
            ra = {5'(i), 5'(i)};
            #1;
            if (rd !== 64'd0 || rd_nb !== 64'd0) nz++;
        end
        cmp++;
        if (nz != 0) begin bad++; $display("FAIL mid-sweep contents: got %0d nonzero want 0", nz); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_collision();
        test_zero();
        test_bypass();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
